// File: rtl/alt_eyemon_dprio_responder.sv
// alt_eyemon_dprio_responder: DPRIO target with programmable busy latency
// backing a windowed shadow register file.
// Optional feature: define ALT_EYEMON_DPRIO_ERRCNT_EN to add o_err_count,
// a saturating count of address and protocol error events.
module alt_eyemon_dprio_responder #(
  parameter int unsigned                  DPRIO_ADDR_WIDTH = 16,
  parameter int unsigned                  DPRIO_DATA_WIDTH = 16,
  parameter int unsigned                  REG_ADDR_WIDTH   = 4,
  parameter logic [DPRIO_ADDR_WIDTH-1:0]  BASE_ADDR        = '0,
  parameter int unsigned                  WR_LATENCY       = 4,
  parameter int unsigned                  RD_LATENCY       = 6
) (
  input  logic                        i_avmm_clk,
  input  logic                        i_reset,
  input  logic                        i_dprio_wren,
  input  logic                        i_dprio_rden,
  input  logic [DPRIO_ADDR_WIDTH-1:0] i_dprio_addr,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_dprio_data,
  output logic                        o_dprio_busy,
  output logic [DPRIO_DATA_WIDTH-1:0] o_dprio_in,
  output logic                        o_addr_err,
`ifdef ALT_EYEMON_DPRIO_ERRCNT_EN
  output logic                        o_proto_err,
  output logic [7:0]                  o_err_count
`else
  output logic                        o_proto_err
`endif
);

  localparam int unsigned DEPTH = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned TAG_W = DPRIO_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [TAG_W-1:0] BASE_TAG = BASE_ADDR[DPRIO_ADDR_WIDTH-1:REG_ADDR_WIDTH];

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_BUSY = 2'd1;
  localparam logic [1:0] ST_RD_BUSY = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [DPRIO_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DPRIO_DATA_WIDTH-1:0] data_q, data_d;
  logic [DPRIO_DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DPRIO_DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DPRIO_DATA_WIDTH-1:0] dout_q, dout_d;
  logic                        busy_q, busy_d;
  logic                        addr_err_q, addr_err_d;
  logic                        proto_err_q, proto_err_d;
  logic [7:0]                  err_cnt_q, err_cnt_d;

  logic                        hit;
  logic [REG_ADDR_WIDTH-1:0]   idx;
  logic                        addr_ev;
  logic                        proto_ev;
  logic [8:0]                  err_sum;

  // Next-state: request acceptance, busy countdown, commit/return on completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    regs_d      = regs_q;
    dout_d      = dout_q;
    addr_ev     = 1'b0;
    proto_ev    = 1'b0;
    hit         = (addr_q[DPRIO_ADDR_WIDTH-1:REG_ADDR_WIDTH] == BASE_TAG);
    idx         = addr_q[REG_ADDR_WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (i_dprio_wren) begin
          addr_d   = i_dprio_addr;
          data_d   = i_dprio_data;
          cnt_d    = 8'(WR_LATENCY);
          state_d  = ST_WR_BUSY;
          proto_ev = i_dprio_rden;
        end else if (i_dprio_rden) begin
          addr_d   = i_dprio_addr;
          cnt_d    = 8'(RD_LATENCY);
          state_d  = ST_RD_BUSY;
        end
      end
      ST_WR_BUSY: begin
        proto_ev = i_dprio_wren | i_dprio_rden;
        if (cnt_q == 8'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          if (hit) regs_d[idx] = data_q;
          else     addr_ev     = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RD_BUSY: begin
        proto_ev = i_dprio_wren | i_dprio_rden;
        if (cnt_q == 8'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          if (hit) dout_d = regs_q[idx];
          else begin
            dout_d  = '1;
            addr_ev = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    addr_err_d  = addr_err_q | addr_ev;
    proto_err_d = proto_err_q | proto_ev;
    err_sum     = 9'(err_cnt_q) + 9'(addr_ev) + 9'(proto_ev);
    err_cnt_d   = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  // State and output registers; synchronous reset aborts any operation in flight
  always_ff @(posedge i_avmm_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      data_q      <= '0;
      dout_q      <= '0;
      busy_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
      err_cnt_q   <= err_cnt_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign o_dprio_busy = busy_q;
  assign o_dprio_in   = dout_q;
  assign o_addr_err   = addr_err_q;
  assign o_proto_err  = proto_err_q;
`ifdef ALT_EYEMON_DPRIO_ERRCNT_EN
  assign o_err_count  = err_cnt_q;
`endif

endmodule
